// File: rtl/ahb_master_fsm.sv
// AHB-Lite command engine of the AXI-to-AHB bridge: pops one command from the
// clock-crossing FIFOs, runs a single AHB transfer and pushes the result back.
module ahb_master_fsm #(
   parameter int AXI_ID_WIDTH = 8
) (
   input  logic                    hclk,
   input  logic                    hreset,
   input  logic                    ahb_write,
   input  logic                    state_fifo_empty,
   output logic                    state_r_en,
   input  logic [31:0]             ahb_addr,
   input  logic                    addr_fifo_empty,
   output logic                    addr_r_en,
   input  logic [2:0]              ahb_size,
   input  logic                    size_fifo_empty,
   output logic                    size_r_en,
   input  logic [AXI_ID_WIDTH:0]   ahb_id,
   input  logic                    id_send_fifo_empty,
   output logic                    id_send_r_en,
   input  logic [63:0]             ahb_data,
   input  logic                    data_fifo_empty,
   output logic                    data_r_en,
   input  logic                    rdata_fifo_full,
   output logic                    rdata_w_en,
   output logic [63:0]             ahb_rdata,
   input  logic                    resp_fifo_full,
   output logic                    resp_w_en,
   output logic [1:0]              ahb_resp,
   input  logic                    id_resp_fifo_full,
   output logic                    id_resp_w_en,
   output logic [AXI_ID_WIDTH+1:0] ahb_id_resp,
   output logic [31:0]             haddr,
   output logic [1:0]              htrans,
   output logic                    hwrite,
   output logic [2:0]              hsize,
   output logic [2:0]              hburst,
   output logic [3:0]              hprot,
   output logic [63:0]             hwdata,
   input  logic [63:0]             hrdata,
   input  logic                    hready,
   input  logic                    hresp
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t                    state_q, state_d;
   logic                      cmd_write_q;
   logic [31:0]               cmd_addr_q;
   logic [2:0]                cmd_size_q;
   logic [AXI_ID_WIDTH:0]     cmd_id_q;
   logic [63:0]               cmd_data_q;
   logic                      err_q, err_d;
   logic                      rdata_w_en_q, rdata_w_en_d;
   logic                      rsp_w_en_q, rsp_w_en_d;
   logic [63:0]               rdata_q;
   logic [1:0]                resp_q, resp_d;
   logic [AXI_ID_WIDTH+1:0]   id_resp_q;
   logic                      start;
   logic                      pop;
   logic                      done;
   logic                      cmd_last;

   assign cmd_last = cmd_id_q[AXI_ID_WIDTH];

   // Everything needed for the whole transfer must be available up front,
   // so a command is never popped partially or left without a result slot.
   always_comb begin
      start = !state_fifo_empty && !addr_fifo_empty && !size_fifo_empty &&
              !id_send_fifo_empty && !resp_fifo_full && !id_resp_fifo_full &&
              (ahb_write ? !data_fifo_empty : !rdata_fifo_full);
      pop   = (state_q == IDLE) && start;
      done  = (state_q == DATA) && hready;
   end

   assign state_r_en   = pop;
   assign addr_r_en    = pop;
   assign size_r_en    = pop;
   assign id_send_r_en = pop;
   assign data_r_en    = pop && ahb_write;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)  state_d = ADDR;
         ADDR:    if (hready) state_d = DATA;
         DATA:    if (hready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      err_d        = err_q;
      rdata_w_en_d = 1'b0;
      rsp_w_en_d   = 1'b0;
      resp_d       = hresp ? 2'b10 : 2'b00;
      if (done) begin
         if (cmd_write_q) begin
            // Error on any beat of a write burst is reported on the last beat.
            if (err_q || hresp) resp_d = 2'b10;
            if (cmd_last) begin
               rsp_w_en_d = 1'b1;
               err_d      = 1'b0;
            end else begin
               err_d = err_q | hresp;
            end
         end else begin
            rdata_w_en_d = 1'b1;
            rsp_w_en_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q      <= IDLE;
         cmd_write_q  <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_size_q   <= '0;
         cmd_id_q     <= '0;
         cmd_data_q   <= '0;
         err_q        <= 1'b0;
         rdata_w_en_q <= 1'b0;
         rsp_w_en_q   <= 1'b0;
         rdata_q      <= '0;
         resp_q       <= '0;
         id_resp_q    <= '0;
      end else begin
         state_q      <= state_d;
         err_q        <= err_d;
         rdata_w_en_q <= rdata_w_en_d;
         rsp_w_en_q   <= rsp_w_en_d;
         if (pop) begin
            cmd_write_q <= ahb_write;
            cmd_addr_q  <= ahb_addr;
            cmd_size_q  <= ahb_size;
            cmd_id_q    <= ahb_id;
            cmd_data_q  <= ahb_write ? ahb_data : '0;
         end
         if (rdata_w_en_d) rdata_q <= hrdata;
         if (rsp_w_en_d) begin
            resp_q    <= resp_d;
            id_resp_q <= {cmd_write_q, cmd_id_q};
         end
      end
   end

   assign rdata_w_en   = rdata_w_en_q;
   assign resp_w_en    = rsp_w_en_q;
   assign id_resp_w_en = rsp_w_en_q;
   assign ahb_rdata    = rdata_q;
   assign ahb_resp     = resp_q;
   assign ahb_id_resp  = id_resp_q;

   assign htrans = (state_q == ADDR) ? 2'b10 : 2'b00;
   assign haddr  = cmd_addr_q;
   assign hwrite = cmd_write_q;
   assign hsize  = cmd_size_q;
   assign hwdata = cmd_data_q;
   assign hburst = 3'b000;
   assign hprot  = 4'b0011;

endmodule

// File: tb/tb_ahb_master_fsm.sv
// Directed bench for ahb_master_fsm: read, write bursts, error, stalls, reset.
module tb_ahb_master_fsm;

   localparam int W = 8;

   logic          hclk = 1'b0;
   logic          hreset;
   logic          ahb_write;
   logic          state_fifo_empty;
   logic          state_r_en;
   logic [31:0]   ahb_addr;
   logic          addr_fifo_empty;
   logic          addr_r_en;
   logic [2:0]    ahb_size;
   logic          size_fifo_empty;
   logic          size_r_en;
   logic [W:0]    ahb_id;
   logic          id_send_fifo_empty;
   logic          id_send_r_en;
   logic [63:0]   ahb_data;
   logic          data_fifo_empty;
   logic          data_r_en;
   logic          rdata_fifo_full;
   logic          rdata_w_en;
   logic [63:0]   ahb_rdata;
   logic          resp_fifo_full;
   logic          resp_w_en;
   logic [1:0]    ahb_resp;
   logic          id_resp_fifo_full;
   logic          id_resp_w_en;
   logic [W+1:0]  ahb_id_resp;
   logic [31:0]   haddr;
   logic [1:0]    htrans;
   logic          hwrite;
   logic [2:0]    hsize;
   logic [2:0]    hburst;
   logic [3:0]    hprot;
   logic [63:0]   hwdata;
   logic [63:0]   hrdata;
   logic          hready;
   logic          hresp;

   int checks = 0;
   int errors = 0;

   ahb_master_fsm #(.AXI_ID_WIDTH(W)) dut (
      .hclk(hclk), .hreset(hreset),
      .ahb_write(ahb_write), .state_fifo_empty(state_fifo_empty),
      .state_r_en(state_r_en),
      .ahb_addr(ahb_addr), .addr_fifo_empty(addr_fifo_empty),
      .addr_r_en(addr_r_en),
      .ahb_size(ahb_size), .size_fifo_empty(size_fifo_empty),
      .size_r_en(size_r_en),
      .ahb_id(ahb_id), .id_send_fifo_empty(id_send_fifo_empty),
      .id_send_r_en(id_send_r_en),
      .ahb_data(ahb_data), .data_fifo_empty(data_fifo_empty),
      .data_r_en(data_r_en),
      .rdata_fifo_full(rdata_fifo_full), .rdata_w_en(rdata_w_en),
      .ahb_rdata(ahb_rdata),
      .resp_fifo_full(resp_fifo_full), .resp_w_en(resp_w_en),
      .ahb_resp(ahb_resp),
      .id_resp_fifo_full(id_resp_fifo_full), .id_resp_w_en(id_resp_w_en),
      .ahb_id_resp(ahb_id_resp),
      .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
      .hburst(hburst), .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata),
      .hready(hready), .hresp(hresp)
   );

   always #5 hclk = ~hclk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic no_cmd();
      state_fifo_empty   = 1'b1;
      addr_fifo_empty    = 1'b1;
      size_fifo_empty    = 1'b1;
      id_send_fifo_empty = 1'b1;
      data_fifo_empty    = 1'b1;
   endtask

   task automatic put_cmd(input logic wr, input logic [31:0] a,
                          input logic [2:0] sz, input logic [7:0] id,
                          input logic last, input logic [63:0] wd,
                          input logic dempty);
      ahb_write          = wr;
      ahb_addr           = a;
      ahb_size           = sz;
      ahb_id             = {last, id};
      ahb_data           = wd;
      state_fifo_empty   = 1'b0;
      addr_fifo_empty    = 1'b0;
      size_fifo_empty    = 1'b0;
      id_send_fifo_empty = 1'b0;
      data_fifo_empty    = dempty;
   endtask

   // Starts in IDLE; returns in the push cycle (pop cycle + 3 + waits).
   task automatic xfer(input logic wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [7:0] id,
                       input logic last, input logic [63:0] wd,
                       input logic [63:0] rd, input logic err,
                       input int aw, input int dw, input logic [1:0] eresp);
      logic       push;
      logic [9:0] eid;
      push = !wr || last;
      eid  = {wr, last, id};
      put_cmd(wr, a, sz, id, last, wd, !wr);
      #1;
      chk("pop_state_r_en", 64'(state_r_en), 64'(1'b1));
      chk("pop_addr_r_en", 64'(addr_r_en), 64'(1'b1));
      chk("pop_id_r_en", 64'(id_send_r_en), 64'(1'b1));
      chk("pop_data_r_en", 64'(data_r_en), 64'(wr));
      chk("pop_htrans", 64'(htrans), 64'(2'b00));
      tick();
      no_cmd();
      for (int k = 0; k <= aw; k++) begin
         hready = (k == aw);
         #1;
         chk("addr_htrans", 64'(htrans), 64'(2'b10));
         chk("addr_haddr", 64'(haddr), 64'(a));
         chk("addr_hwrite", 64'(hwrite), 64'(wr));
         chk("addr_hsize", 64'(hsize), 64'(sz));
         chk("addr_hburst", 64'(hburst), 64'(3'b000));
         chk("addr_hprot", 64'(hprot), 64'(4'b0011));
         chk("addr_r_en", 64'(state_r_en), 64'(1'b0));
         tick();
      end
      for (int k = 0; k <= dw; k++) begin
         hready = (k == dw);
         hresp  = err;
         hrdata = rd;
         #1;
         chk("data_htrans", 64'(htrans), 64'(2'b00));
         if (wr) chk("data_hwdata", hwdata, wd);
         chk("data_resp_w_en", 64'(resp_w_en), 64'(1'b0));
         tick();
      end
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = 64'h0;
      #1;
      chk("push_rdata_w_en", 64'(rdata_w_en), 64'(!wr));
      chk("push_resp_w_en", 64'(resp_w_en), 64'(push));
      chk("push_id_w_en", 64'(id_resp_w_en), 64'(push));
      chk("push_htrans", 64'(htrans), 64'(2'b00));
      if (push) begin
         chk("push_resp", 64'(ahb_resp), 64'(eresp));
         chk("push_id_resp", 64'(ahb_id_resp), 64'(eid));
      end
      if (!wr) chk("push_rdata", ahb_rdata, rd);
   endtask

   initial begin
      hreset            = 1'b1;
      ahb_write         = 1'b0;
      ahb_addr          = 32'h0;
      ahb_size          = 3'd0;
      ahb_id            = '0;
      ahb_data          = 64'h0;
      rdata_fifo_full   = 1'b0;
      resp_fifo_full    = 1'b0;
      id_resp_fifo_full = 1'b0;
      hrdata            = 64'h0;
      hready            = 1'b1;
      hresp             = 1'b0;
      no_cmd();
      tick();
      tick();
      chk("rst_htrans", 64'(htrans), 64'(2'b00));
      chk("rst_haddr", 64'(haddr), 64'(0));
      chk("rst_hwdata", hwdata, 64'h0);
      chk("rst_w_en", 64'({rdata_w_en, resp_w_en, id_resp_w_en}), 64'(0));
      chk("rst_id_resp", 64'(ahb_id_resp), 64'(0));
      hreset = 1'b0;
      tick();

      // single read
      xfer(1'b0, 32'h1000_0040, 3'd3, 8'h15, 1'b1, 64'h0,
           64'hDEAD_BEEF_0123_4567, 1'b0, 0, 0, 2'b00);
      chk("push_rdata_val", ahb_rdata, 64'hDEAD_BEEF_0123_4567);
      chk("push_id_val", 64'(ahb_id_resp), 64'h115);
      tick();
      chk("post_push_w_en", 64'({rdata_w_en, resp_w_en}), 64'(0));

      // clean 4-beat write burst, back-to-back
      for (int i = 0; i < 4; i++)
         xfer(1'b1, 32'h2000_0000 + 32'(i * 8), 3'd3, 8'h03, i == 3,
              64'hA5A5_0000_0000_0000 + 64'(i), 64'h0, 1'b0, 0, 0, 2'b00);
      chk("burst_id_val", 64'(ahb_id_resp), 64'h303);
      tick();
      chk("burst_w_en_low", 64'(resp_w_en), 64'(0));

      // error on beat 2 (two-cycle ERROR) reported on last beat
      for (int i = 0; i < 4; i++)
         xfer(1'b1, 32'h3000_0000 + 32'(i * 8), 3'd2, 8'h07, i == 3,
              64'h5A5A_0000_1111_0000 + 64'(i), 64'h0, i == 1,
              0, (i == 1) ? 1 : 0, (i == 3) ? 2'b10 : 2'b00);
      tick();
      // next clean burst proves the sticky error was cleared
      for (int i = 0; i < 2; i++)
         xfer(1'b1, 32'h3100_0000, 3'd3, 8'h08, i == 1,
              64'h0123_0000_0000_0000 + 64'(i), 64'h0, 1'b0, 0, 0, 2'b00);
      tick();

      // response FIFO full blocks the pop
      put_cmd(1'b0, 32'h4000_0010, 3'd3, 8'h21, 1'b1, 64'h0, 1'b1);
      resp_fifo_full = 1'b1;
      #1;
      chk("bp_state_r_en", 64'(state_r_en), 64'(1'b0));
      chk("bp_size_r_en", 64'(size_r_en), 64'(1'b0));
      chk("bp_htrans", 64'(htrans), 64'(2'b00));
      tick();
      chk("bp_htrans2", 64'(htrans), 64'(2'b00));
      id_resp_fifo_full = 1'b1;
      resp_fifo_full    = 1'b0;
      #1;
      chk("bp_idfull_r_en", 64'(state_r_en), 64'(1'b0));
      tick();
      id_resp_fifo_full = 1'b0;
      rdata_fifo_full   = 1'b1;
      #1;
      chk("bp_rdfull_r_en", 64'(state_r_en), 64'(1'b0));
      tick();
      rdata_fifo_full = 1'b0;
      // release: pop now, 3 ADDR and 2 DATA wait states, push at N+8
      xfer(1'b0, 32'h4000_0010, 3'd3, 8'h21, 1'b1, 64'h0,
           64'hCAFE_F00D_0000_0001, 1'b0, 3, 2, 2'b00);
      tick();

      // write without data waits in IDLE
      put_cmd(1'b1, 32'h5000_0000, 3'd3, 8'h09, 1'b1, 64'h7777, 1'b1);
      #1;
      chk("nodata_state_r_en", 64'(state_r_en), 64'(1'b0));
      chk("nodata_data_r_en", 64'(data_r_en), 64'(1'b0));
      tick();
      chk("nodata_htrans", 64'(htrans), 64'(2'b00));
      xfer(1'b1, 32'h5000_0000, 3'd3, 8'h09, 1'b1, 64'h7777_8888_9999_AAAA,
           64'h0, 1'b0, 0, 0, 2'b00);
      tick();

      // reset during DATA
      put_cmd(1'b1, 32'h6000_0008, 3'd3, 8'h0A, 1'b1, 64'hFEED_FACE_0000_0001,
              1'b0);
      tick();
      no_cmd();
      chk("rs_addr_htrans", 64'(htrans), 64'(2'b10));
      tick();
      hready = 1'b0;
      #1;
      chk("rs_data_hwdata", hwdata, 64'hFEED_FACE_0000_0001);
      hreset = 1'b1;
      #1;
      chk("rs_htrans", 64'(htrans), 64'(2'b00));
      chk("rs_haddr", 64'(haddr), 64'(0));
      chk("rs_hwrite", 64'(hwrite), 64'(0));
      chk("rs_hsize", 64'(hsize), 64'(0));
      chk("rs_hwdata", hwdata, 64'h0);
      chk("rs_rdata", ahb_rdata, 64'h0);
      chk("rs_resp", 64'(ahb_resp), 64'(0));
      chk("rs_id_resp", 64'(ahb_id_resp), 64'(0));
      hready = 1'b1;
      tick();
      chk("rs_w_en", 64'({rdata_w_en, resp_w_en, id_resp_w_en}), 64'(0));
      hreset = 1'b0;
      tick();
      chk("rs_no_push", 64'({rdata_w_en, resp_w_en, id_resp_w_en}), 64'(0));
      chk("rs_idle", 64'(htrans), 64'(2'b00));
      xfer(1'b0, 32'h7000_0000, 3'd2, 8'h33, 1'b0, 64'h0,
           64'h1122_3344_5566_7788, 1'b1, 0, 0, 2'b10);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
